// File: rtl/mul_share_ctrl.sv
// Shares one external sign-magnitude multiplier among NREQ requesters: round-robin grant,
// operand/result conversion, two-stage valid/ready pipeline. Define MUL_SAT_EN to saturate on overflow.
module mul_share_ctrl #(
    parameter int BITS = 16,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic [BITS-1:0]      mul_a,
    output logic [BITS-1:0]      mul_b,
    output logic [BITS-1:0]      mul_a_map,
    output logic                 mul_sign_a,
    output logic                 mul_sign_b,
    input  logic [BITS-1:0]      mul_m,
    input  logic                 mul_over,
    input  logic                 mul_turn,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_m,
    output logic                 rsp_over,
    output logic                 busy
);

    localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] MAX_VAL = ~MIN_VAL;

    // Stage S1 (operands) and S2 (result) state
    logic            v1_q, sa1_q, sb1_q;
    logic [BITS-1:0] a1_q, b1_q, map1_q;
    logic [IDW-1:0]  id1_q;
    logic            v2_q, over2_q;
    logic [BITS-1:0] m2_q;
    logic [IDW-1:0]  id2_q;
    logic [IDW-1:0]  ptr_q;

    logic            adv1, adv2, accept, win_found;
    logic [IDW-1:0]  win_id, ptr_d;
    logic [BITS-1:0] sel_a, sel_b, mag_a, mag_b, map_d;
    logic            res_neg, over_d;
    logic [BITS-1:0] res_d;

    assign adv2   = !v2_q || rsp_ready;
    assign adv1   = !v1_q || adv2;
    assign accept = win_found && adv1 && !rst;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
        ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
    end

    always_comb begin
        sel_a = req_a[win_id*BITS +: BITS];
        sel_b = req_b[win_id*BITS +: BITS];
        mag_a = sel_a[BITS-1] ? -sel_a : sel_a;
        mag_b = sel_b[BITS-1] ? -sel_b : sel_b;
        // a_map[k] is set when any magnitude bit above k is set
        map_d = '0;
        for (int k = BITS - 2; k >= 0; k--) map_d[k] = map_d[k+1] | mag_a[k+1];
    end

    always_comb begin
        res_neg = mul_turn && (mul_m != '0);
        over_d  = mul_over || (mul_m[BITS-1] && !(res_neg && (mul_m == MIN_VAL)));
        res_d   = res_neg ? -mul_m : mul_m;
`ifdef MUL_SAT_EN
        if (over_d) res_d = mul_turn ? MIN_VAL : MAX_VAL;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sa1_q   <= 1'b0;
            sb1_q   <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            map1_q  <= '0;
            id1_q   <= '0;
            v2_q    <= 1'b0;
            over2_q <= 1'b0;
            m2_q    <= '0;
            id2_q   <= '0;
            ptr_q   <= '0;
        end else begin
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    m2_q    <= res_d;
                    over2_q <= over_d;
                    id2_q   <= id1_q;
                end
            end
            if (accept) begin
                v1_q   <= 1'b1;
                a1_q   <= mag_a;
                b1_q   <= mag_b;
                map1_q <= map_d;
                sa1_q  <= sel_a[BITS-1];
                sb1_q  <= sel_b[BITS-1];
                id1_q  <= win_id;
                ptr_q  <= ptr_d;
            end else if (adv2) begin
                v1_q <= 1'b0;
            end
        end
    end

    assign mul_a      = a1_q;
    assign mul_b      = b1_q;
    assign mul_a_map  = map1_q;
    assign mul_sign_a = sa1_q;
    assign mul_sign_b = sb1_q;
    assign rsp_valid  = v2_q;
    assign rsp_id     = id2_q;
    assign rsp_m      = m2_q;
    assign rsp_over   = over2_q;
    assign busy       = v1_q || v2_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural sign-magnitude multiplier on the mul_* ports.
module tb_mul_share_ctrl;

    localparam int BITS = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*BITS-1:0] req_a, req_b;
    logic [BITS-1:0]      mul_a, mul_b, mul_a_map, mul_m;
    logic                 mul_sign_a, mul_sign_b, mul_over, mul_turn;
    logic                 rsp_valid, rsp_ready, rsp_over, busy;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_m;
    logic [2*BITS-1:0]    prod;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Multiplier model: magnitude product, overflow when it exceeds BITS bits, sign = xor
    assign prod     = {{BITS{1'b0}}, mul_a} * {{BITS{1'b0}}, mul_b};
    assign mul_m    = prod[BITS-1:0];
    assign mul_over = |prod[2*BITS-1:BITS];
    assign mul_turn = mul_sign_a ^ mul_sign_b;

    mul_share_ctrl #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_map(mul_a_map),
        .mul_sign_a(mul_sign_a), .mul_sign_b(mul_sign_b),
        .mul_m(mul_m), .mul_over(mul_over), .mul_turn(mul_turn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_m(rsp_m), .rsp_over(rsp_over), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        req_a[i*BITS +: BITS] = a;
        req_b[i*BITS +: BITS] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset req_ready: got %h want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (mul_a !== 16'h0 || mul_a_map !== 16'h0) begin n_err++; $display("FAIL reset mul: got a=%h map=%h want 0", mul_a, mul_a_map); end
        n_cmp++; if (rsp_m !== 16'h0 || rsp_over !== 1'b0) begin n_err++; $display("FAIL reset rsp: got m=%h over=%b want 0", rsp_m, rsp_over); end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [BITS-1:0] exp_m [4] = '{16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF8};
        for (int i = 0; i < NREQ; i++) set_slot(i, 16'(i + 1), 16'hFFFE);
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                n_cmp++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    n_err++; $display("FAIL rr grant c%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= 2 && c < 10) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'((c - 2) % 4) || rsp_m !== exp_m[(c - 2) % 4]) begin
                    n_err++; $display("FAIL rr rsp c%0d: got v=%b id=%0d m=%h want v=1 id=%0d m=%h",
                                      c, rsp_valid, rsp_id, rsp_m, (c - 2) % 4, exp_m[(c - 2) % 4]);
                end
            end else begin
                n_cmp++;
                if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr idle c%0d: got rsp_valid=%b want 0", c, rsp_valid); end
            end
            step();
        end
    endtask

    task automatic run_op(input string name, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [BITS-1:0] exp_m, input logic exp_over, input logic [BITS-1:0] exp_map);
        set_slot(0, a, b);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL %s ready: got %b want 0001", name, req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s stage1: got v=%b busy=%b want 0/1", name, rsp_valid, busy); end
        n_cmp++; if (mul_a_map !== exp_map) begin n_err++; $display("FAIL %s a_map: got %h want %h", name, mul_a_map, exp_map); end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_m !== exp_m || rsp_over !== exp_over || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL %s rsp: got v=%b m=%h over=%b id=%0d want v=1 m=%h over=%b id=0",
                              name, rsp_valid, rsp_m, rsp_over, rsp_id, exp_m, exp_over);
        end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s drain: got rsp_valid=%b want 0", name, rsp_valid); end
    endtask

    task automatic test_basic();
        run_op("3x-5", 16'h0003, 16'hFFFB, 16'hFFF1, 1'b0, 16'h0001);
    endtask

    task automatic test_overflow();
`ifdef MUL_SAT_EN
        run_op("256x256", 16'h0100, 16'h0100, 16'h7FFF, 1'b1, 16'h00FF);
        run_op("-256x256", 16'hFF00, 16'h0100, 16'h8000, 1'b1, 16'h00FF);
`else
        run_op("256x256", 16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h00FF);
        run_op("-256x256", 16'hFF00, 16'h0100, 16'h0000, 1'b1, 16'h00FF);
`endif
    endtask

    task automatic test_boundary();
        run_op("min x 1", 16'h8000, 16'h0001, 16'h8000, 1'b0, 16'h7FFF);
`ifdef MUL_SAT_EN
        run_op("min x -1", 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 16'h7FFF);
`else
        run_op("min x -1", 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF);
`endif
        run_op("0 x -7", 16'h0000, 16'hFFF9, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic test_back_to_back_backpressure();
        logic            t_rdy   [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic            t_val   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        int              t_op    [9] = '{0, 1, 2, 2, 2, 2, 0, 0, 0};
        logic [3:0]      t_grant [9] = '{4'h4, 4'h4, 0, 0, 0, 4'h4, 0, 0, 0};
        logic            t_rv    [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [BITS-1:0] t_m     [9] = '{0, 0, 16'h6, 16'h6, 16'h6, 16'h6, 16'h14, 16'h2A, 0};
        logic [BITS-1:0] op_a    [3] = '{16'd2, 16'd4, 16'd6};
        logic [BITS-1:0] op_b    [3] = '{16'd3, 16'd5, 16'd7};
        for (int c = 0; c < 9; c++) begin
            rsp_ready = t_rdy[c];
            req_valid = t_val[c] ? 4'b0100 : 4'b0000;
            set_slot(2, op_a[t_op[c]], op_b[t_op[c]]);
            #1;
            n_cmp++;
            if (req_ready !== t_grant[c]) begin n_err++; $display("FAIL bp grant c%0d: got %b want %b", c, req_ready, t_grant[c]); end
            n_cmp++;
            if (rsp_valid !== t_rv[c] || (t_rv[c] && (rsp_m !== t_m[c] || rsp_id !== 2'd2))) begin
                n_err++; $display("FAIL bp rsp c%0d: got v=%b m=%h id=%0d want v=%b m=%h id=2",
                                  c, rsp_valid, rsp_m, rsp_id, t_rv[c], t_m[c]);
            end
            step();
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp idle busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < NREQ; i++) set_slot(i, 16'd5, 16'd5);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step();
        step();
        n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL rst-mid loaded: got busy=%b v=%b want 1/1", busy, rsp_valid); end
        rst = 1'b1;
        step();
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst-mid flush: got v=%b busy=%b want 0/0", rsp_valid, busy); end
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rst-mid ready: got %b want 0000", req_ready); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst-mid first grant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst-mid stale rsp: got v=%b want 0", rsp_valid); end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_m !== 16'h0019) begin
            n_err++; $display("FAIL rst-mid rsp: got v=%b id=%0d m=%h want v=1 id=0 m=0019", rsp_valid, rsp_id, rsp_m);
        end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst-mid drain busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_overflow();
        test_boundary();
        test_back_to_back_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
